// File: rtl/pattern_pkg.sv
// Shared definitions for the test-pattern generator: mode encodings,
// 3-bit {b,g,r} colour codes and the code-to-channel expansion helper.
// No logic, no latency, no flow control.
package pattern_pkg;

    // Width of the pixel coordinate and scroll-offset buses.
    localparam int XY_W = 10;

    typedef enum logic [1:0] {
        MODE_BARS   = 2'd0,   // static colour bars
        MODE_SCROLL = 2'd1,   // bars scrolling left by one step per frame
        MODE_CHECK  = 2'd2,   // checkerboard whose phase flips every 16 frames
        MODE_CYCLE  = 2'd3    // whole screen steps through the 8 colours
    } mode_e;

    // Colour codes, bit 0 = red, bit 1 = green, bit 2 = blue.
    localparam logic [2:0] CODE_BLACK   = 3'd0;
    localparam logic [2:0] CODE_RED     = 3'd1;
    localparam logic [2:0] CODE_GREEN   = 3'd2;
    localparam logic [2:0] CODE_YELLOW  = 3'd3;
    localparam logic [2:0] CODE_BLUE    = 3'd4;
    localparam logic [2:0] CODE_MAGENTA = 3'd5;
    localparam logic [2:0] CODE_CYAN    = 3'd6;
    localparam logic [2:0] CODE_WHITE   = 3'd7;

    // Channel selectors for code_to_chan.
    localparam logic [1:0] CH_R = 2'd0;
    localparam logic [1:0] CH_G = 2'd1;
    localparam logic [1:0] CH_B = 2'd2;

    // Returns 1 when the selected channel of a colour code is lit; the
    // caller replicates it to the full channel width (all-ones or zero).
    function automatic logic code_to_chan(input logic [2:0] code, input logic [1:0] ch);
        logic on;
        case (ch)
            CH_R:    on = code[0];
            CH_G:    on = code[1];
            default: on = code[2];
        endcase
        return on;
    endfunction

endpackage

// File: rtl/pattern_frame_ctrl.sv
// Per-frame state of the pattern generator: pending/active mode, scroll
// offset, checker phase, colour-cycle index and frame counter.
// Updates only on frame_start (mode_load captures any cycle); no backpressure.
//
// Ports: clock/resetn; frame_start, mode_load, mode_sel in;
//        mode, offset, phase, cyc out (all registered).
module pattern_frame_ctrl
    import pattern_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int SCROLL_STEP = 4,
    parameter int HOLD_FRAMES = 60
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            frame_start,
    input  logic            mode_load,
    input  logic [1:0]      mode_sel,
    output logic [1:0]      mode,
    output logic [XY_W-1:0] offset,
    output logic            phase,
    output logic [2:0]      cyc
);

    // The counter must hold HOLD_FRAMES-1 and also provide the low 4 bits
    // used for the every-16-frames checker flip.
    localparam int FCNT_W = (HOLD_FRAMES > 16) ? $clog2(HOLD_FRAMES) : 4;
    localparam logic [FCNT_W-1:0] HOLD_LAST = FCNT_W'(HOLD_FRAMES - 1);
    localparam logic [XY_W:0]     H_LIM     = (XY_W+1)'(H_ACTIVE);
    localparam logic [XY_W:0]     STEP      = (XY_W+1)'(SCROLL_STEP);

    mode_e             pend_q, act_q;
    mode_e             pend_d, act_d, next_mode;
    logic [XY_W-1:0]   off_q, off_d;
    logic [XY_W:0]     off_sum;
    logic              ph_q, ph_d;
    logic [2:0]        cyc_q, cyc_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d, fcnt_inc;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pend_q <= MODE_BARS;
            act_q  <= MODE_BARS;
            off_q  <= '0;
            ph_q   <= 1'b0;
            cyc_q  <= '0;
            fcnt_q <= '0;
        end else begin
            pend_q <= pend_d;
            act_q  <= act_d;
            off_q  <= off_d;
            ph_q   <= ph_d;
            cyc_q  <= cyc_d;
            fcnt_q <= fcnt_d;
        end
    end

    always_comb begin
        pend_d   = pend_q;
        act_d    = act_q;
        off_d    = off_q;
        ph_d     = ph_q;
        cyc_d    = cyc_q;
        fcnt_d   = fcnt_q;
        off_sum  = {1'b0, off_q} + STEP;
        fcnt_inc = fcnt_q + 1'b1;

        // A load coinciding with frame_start takes effect at that frame.
        next_mode = mode_load ? mode_e'(mode_sel) : pend_q;
        if (mode_load) begin
            pend_d = mode_e'(mode_sel);
        end

        if (frame_start) begin
            act_d = next_mode;
            if (next_mode != act_q) begin
                // Every animation restarts from a clean state on a mode switch.
                off_d  = '0;
                ph_d   = 1'b0;
                cyc_d  = '0;
                fcnt_d = '0;
            end else begin
                case (act_q)
                    MODE_SCROLL: begin
                        off_d = (off_sum >= H_LIM) ? XY_W'(off_sum - H_LIM) : off_sum[XY_W-1:0];
                    end
                    MODE_CHECK: begin
                        fcnt_d = fcnt_inc;
                        if (fcnt_inc[3:0] == 4'd0) begin
                            ph_d = ~ph_q;
                        end
                    end
                    MODE_CYCLE: begin
                        if (fcnt_q == HOLD_LAST) begin
                            fcnt_d = '0;
                            cyc_d  = cyc_q + 3'd1;
                        end else begin
                            fcnt_d = fcnt_inc;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign mode   = act_q;
    assign offset = off_q;
    assign phase  = ph_q;
    assign cyc    = cyc_q;

endmodule

// File: rtl/pattern_gen.sv
// Video test-pattern generator: bars, scrolling bars, checkerboard, colour cycle.
// Latency 2 cycles from x/y/pix_valid to r/g/b/out_valid.
// No backpressure: one pixel accepted per cycle whenever pix_valid is high.
//
// Ports: clock, resetn (async active-low); x, y, pix_valid, frame_start,
//        mode_sel, mode_load in; r, g, b (COLOR_W each), out_valid out.
module pattern_gen
    import pattern_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int NUM_BARS    = 8,
    parameter int COLOR_W     = 10,
    parameter int SCROLL_STEP = 4,
    parameter int CHECK_LOG2  = 5,
    parameter int HOLD_FRAMES = 60
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    input  logic               pix_valid,
    input  logic               frame_start,
    input  logic [1:0]         mode_sel,
    input  logic               mode_load,
    output logic [COLOR_W-1:0] r,
    output logic [COLOR_W-1:0] g,
    output logic [COLOR_W-1:0] b,
    output logic               out_valid
);

    localparam int            BW       = H_ACTIVE / NUM_BARS;
    localparam int            CODE_MUL = 8 / NUM_BARS;
    localparam logic [XY_W:0] H_LIM    = (XY_W+1)'(H_ACTIVE);

    logic [1:0]      mode_w;
    mode_e           act_mode;
    logic [XY_W-1:0] offset;
    logic            phase;
    logic [2:0]      cyc;

    pattern_frame_ctrl #(
        .H_ACTIVE    (H_ACTIVE),
        .SCROLL_STEP (SCROLL_STEP),
        .HOLD_FRAMES (HOLD_FRAMES)
    ) u_frame_ctrl (
        .clock       (clock),
        .resetn      (resetn),
        .frame_start (frame_start),
        .mode_load   (mode_load),
        .mode_sel    (mode_sel),
        .mode        (mode_w),
        .offset      (offset),
        .phase       (phase),
        .cyc         (cyc)
    );

    assign act_mode = mode_e'(mode_w);

    // Only one row bit feeds the checkerboard; the rest is intentionally idle.
    logic unused_y;
    assign unused_y = ^y;

    // ---------------- stage 1: colour code ----------------
    logic [XY_W:0]   x_sum;
    logic [XY_W-1:0] xe;
    logic [2:0]      bar_idx;
    logic [2:0]      bar_code;
    logic [2:0]      code_d;
    logic            s1_vld;
    logic [2:0]      s1_code;

    always_comb begin
        x_sum = {1'b0, x} + {1'b0, offset};

        // Both operands are below H_ACTIVE, so one conditional subtract
        // replaces a modulo.
        xe = x;
        if (act_mode == MODE_SCROLL) begin
            xe = (x_sum >= H_LIM) ? XY_W'(x_sum - H_LIM) : x_sum[XY_W-1:0];
        end

        // Bar index by threshold comparison against constant multiples of
        // the bar width: the last boundary passed gives the index.
        bar_idx = '0;
        for (int k = 1; k < NUM_BARS; k++) begin
            if ({1'b0, xe} >= (XY_W+1)'(k * BW)) begin
                bar_idx = 3'(k);
            end
        end
        // Spread the bars over all 8 codes; truncation gives the mod 8.
        bar_code = 3'(32'(bar_idx) * CODE_MUL);

        case (act_mode)
            MODE_BARS, MODE_SCROLL: code_d = bar_code;
            MODE_CHECK:  code_d = (x[CHECK_LOG2] ^ y[CHECK_LOG2] ^ phase) ? CODE_WHITE : CODE_BLACK;
            default:     code_d = cyc;
        endcase

        // Columns beyond the active width are always black.
        if ({1'b0, x} >= H_LIM) begin
            code_d = CODE_BLACK;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1_vld  <= 1'b0;
            s1_code <= CODE_BLACK;
        end else begin
            s1_vld  <= pix_valid;
            s1_code <= pix_valid ? code_d : CODE_BLACK;
        end
    end

    // ---------------- stage 2: channel expansion ----------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r         <= '0;
            g         <= '0;
            b         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= s1_vld;
            r <= s1_vld ? {COLOR_W{code_to_chan(s1_code, CH_R)}} : '0;
            g <= s1_vld ? {COLOR_W{code_to_chan(s1_code, CH_G)}} : '0;
            b <= s1_vld ? {COLOR_W{code_to_chan(s1_code, CH_B)}} : '0;
        end
    end

endmodule

// File: tb/tb_pattern_gen.sv
// Directed bench for pattern_gen with a scoreboard: every issued pixel pushes
// its hand-computed colour code; a monitor pops on out_valid and compares.
// HOLD_FRAMES is shortened to 2 so the colour cycle wraps quickly.
module tb_pattern_gen;

    localparam logic [2:0] BLACK = 3'd0, RED = 3'd1, MAGENTA = 3'd5, WHITE = 3'd7;

    logic       clock = 1'b0;
    logic       resetn;
    logic [9:0] x, y;
    logic       pix_valid, frame_start, mode_load;
    logic [1:0] mode_sel;
    logic [9:0] r, g, b;
    logic       out_valid;

    always #5 clock = ~clock;

    pattern_gen #(
        .H_ACTIVE(640), .NUM_BARS(8), .COLOR_W(10),
        .SCROLL_STEP(4), .CHECK_LOG2(5), .HOLD_FRAMES(2)
    ) dut (
        .clock(clock), .resetn(resetn), .x(x), .y(y),
        .pix_valid(pix_valid), .frame_start(frame_start),
        .mode_sel(mode_sel), .mode_load(mode_load),
        .r(r), .g(g), .b(b), .out_valid(out_valid)
    );

    typedef struct packed {
        logic [2:0]  code;
        logic [31:0] issued;
        logic [15:0] id;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc_n    = 0;
    int   pid      = 0;

    always @(posedge clock) cyc_n <= cyc_n + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [29:0] exp_rgb(input logic [2:0] c);
        return {(c[0] ? 10'h3FF : 10'h000), (c[1] ? 10'h3FF : 10'h000), (c[2] ? 10'h3FF : 10'h000)};
    endfunction

    // Monitor: decoupled from stimulus, checks colour and 2-cycle latency.
    always @(negedge clock) begin
        exp_t e;
        if (out_valid === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got out_valid=1 with rgb=%0h expected no pixel pending", {r, g, b});
            end else begin
                e = q.pop_front();
                check($sformatf("pix%0d_rgb", e.id), 32'({r, g, b}), 32'(exp_rgb(e.code)));
                check($sformatf("pix%0d_latency", e.id), 32'(cyc_n - int'(e.issued)), 32'd2);
            end
        end else begin
            check("idle_rgb_zero", 32'({r, g, b}), 32'd0);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pixel(input int px, input int py, input logic [2:0] code);
        exp_t e;
        x = 10'(px);
        y = 10'(py);
        pix_valid = 1'b1;
        e.code = code;
        e.issued = 32'(cyc_n);
        e.id = 16'(pid);
        q.push_back(e);
        pid++;
        step();
        pix_valid = 1'b0;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            frame_start = 1'b1;
            step();
            frame_start = 1'b0;
        end
    endtask

    task automatic load(input logic [1:0] m);
        mode_sel  = m;
        mode_load = 1'b1;
        step();
        mode_load = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0;
        x = '0; y = '0; pix_valid = 1'b0; frame_start = 1'b0;
        mode_sel = '0; mode_load = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_r", 32'(r), 32'd0);
        check("reset_g", 32'(g), 32'd0);
        check("reset_b", 32'(b), 32'd0);
        resetn = 1'b1;
        step();

        // Mode 0 static bars, 80-pixel bars.
        pixel(0, 0, BLACK);
        pixel(79, 0, BLACK);
        pixel(80, 0, RED);
        pixel(639, 0, WHITE);
        pixel(320, 0, 3'd4);
        pixel(700, 0, BLACK);
        repeat (3) step();
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_r", 32'(r), 32'd0);

        // Mode 1 scrolling bars.
        load(2'd1);
        frames(1);              // enters mode 1, offset 0
        pixel(80, 0, RED);
        frames(1);              // offset 4
        pixel(636, 0, BLACK);   // xe = 640 -> 0
        pixel(76, 0, RED);      // xe = 80
        pixel(79, 0, RED);      // xe = 83
        frames(158);            // offset 636
        pixel(4, 0, BLACK);     // 640 -> 0
        pixel(3, 0, WHITE);     // 639
        frames(1);              // 160 frames: 636+4 wraps to 0
        pixel(79, 0, BLACK);
        pixel(80, 0, RED);

        // Mode 2 loaded mid-frame: bars continue until the next frame_start.
        load(2'd2);
        pixel(80, 0, RED);
        frames(1);
        pixel(32, 0, WHITE);
        pixel(0, 0, BLACK);
        pixel(0, 32, WHITE);
        pixel(32, 32, BLACK);
        pixel(700, 0, BLACK);
        frames(16);             // phase flipped once
        pixel(32, 0, BLACK);
        pixel(0, 0, WHITE);

        // Mode 3 colour cycle, two frames per colour.
        load(2'd3);
        frames(1);
        pixel(0, 0, BLACK);
        frames(2);
        pixel(100, 5, RED);
        frames(8);              // 10 frames -> colour 5
        pixel(0, 0, MAGENTA);
        pixel(700, 0, BLACK);
        frames(6);              // 16 frames -> wrapped to 0
        pixel(0, 0, BLACK);

        // Load coinciding with frame_start switches at that frame.
        mode_sel = 2'd0;
        mode_load = 1'b1;
        frame_start = 1'b1;
        step();
        mode_load = 1'b0;
        frame_start = 1'b0;
        pixel(80, 0, RED);

        // Reset mid-frame in mode 1 with offset 40.
        load(2'd1);
        frames(11);             // entry + 10 frames -> offset 40
        pixel(40, 0, RED);      // xe = 80
        repeat (3) step();
        pixel(40, 0, RED);
        pixel(40, 0, RED);      // first of these now on the outputs
        check("pre_reset_r", 32'(r), 32'h3FF);
        #1;
        resetn = 1'b0;
        #1;
        check("async_reset_out_valid", 32'(out_valid), 32'd0);
        check("async_reset_r", 32'(r), 32'd0);
        q.delete();
        step();
        resetn = 1'b1;
        step();
        pixel(40, 0, BLACK);    // mode 0, bar 0
        pixel(80, 0, RED);
        frames(1);              // pending cleared too: stays in mode 0
        pixel(76, 0, BLACK);

        repeat (5) step();
        check("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pattern_gen.md
PATTERN_GEN -- requirements
Module: pattern_gen

Interface
REQ-001 The block SHALL expose these parameters, one per line:
- H_ACTIVE, 640, active pixels per line.
- NUM_BARS, 8, bar count; legal values 2, 4, 8; H_ACTIVE divisible by NUM_BARS.
- COLOR_W, 10, bits per colour channel.
- SCROLL_STEP, 4, pixels added to the scroll offset per frame.
- CHECK_LOG2, 5, log2 of checker square size.
- HOLD_FRAMES, 60, frames per colour in cycle mode.
REQ-002 The block SHALL expose these ports (one clock; reset is asynchronous and active-low), one per line:
- clock, in, 1, pixel clock.
- resetn, in, 1, asynchronous active-low reset.
- x, in, 10, pixel column.
- y, in, 10, pixel row.
- pix_valid, in, 1, x/y is an active pixel this cycle.
- frame_start, in, 1, one-cycle pulse before the first pixel of a frame.
- mode_sel, in, 2, requested mode.
- mode_load, in, 1, capture mode_sel into the pending-mode register.
- r, out, COLOR_W, red.
- g, out, COLOR_W, green.
- b, out, COLOR_W, blue.
- out_valid, out, 1, r/g/b correspond to the pixel presented 2 cycles earlier.

Function
REQ-003 Modes SHALL be: 0 static bars, 1 scrolling bars, 2 animated checkerboard, 3 full-screen colour cycle.
REQ-004 Colour code SHALL be 3 bits {b,g,r}; each set bit drives its channel to all-ones, each clear bit to zero.
REQ-005 Bar width SHALL be BW = H_ACTIVE/NUM_BARS; bar index i = xe/BW; colour code = (i*8/NUM_BARS) mod 8.
REQ-006 Mode 0 SHALL use xe = x.
REQ-007 Mode 1 SHALL use xe = x + offset, minus H_ACTIVE when the sum is >= H_ACTIVE; no divider.
REQ-008 offset SHALL advance by SCROLL_STEP on each frame_start while the active mode is 1, wrapping modulo H_ACTIVE (636+4 -> 0), and SHALL hold in other modes.
REQ-009 Mode 2 SHALL output white when x[CHECK_LOG2] ^ y[CHECK_LOG2] ^ phase = 1, else black; phase SHALL toggle on every frame_start whose frame count is a multiple of 16.
REQ-010 Mode 3 SHALL output code cyc for every pixel; cyc SHALL increment (wrapping 7 -> 0) after HOLD_FRAMES frame_starts, counted by a frame counter that clears on each increment.
REQ-011 mode_load SHALL capture mode_sel into a pending register; the active mode SHALL take the pending value only on frame_start, so it never changes mid-frame.
REQ-012 If mode_load and frame_start coincide, the new mode_sel SHALL become active at that frame_start.
REQ-013 On an active-mode change, offset, phase, cyc and the frame counter SHALL clear to 0 at the same frame_start.
REQ-014 Pipeline SHALL be 2 cycles: stage 1 registers the colour code and valid, stage 2 registers the channel expansion; out_valid = pix_valid delayed 2 cycles.
REQ-015 When out_valid = 0, r/g/b SHALL be 0.
REQ-016 x >= H_ACTIVE with pix_valid = 1 SHALL produce valid black output.
REQ-017 A frame_start arriving while pixels are in flight SHALL NOT alter those pixels' colours; state updates apply from the next pixel sampled.

Reset
REQ-018 resetn low SHALL asynchronously clear r, g, b, out_valid, pipeline valids, active and pending mode, offset, phase, cyc and the frame counter to 0.
REQ-019 Reset asserted mid-frame SHALL force outputs to 0 immediately; the first pixel with pix_valid at least 2 cycles after release SHALL be rendered in mode 0.

Structure
REQ-020 A shared package pattern_pkg SHALL hold the mode encodings, the 3-bit colour-code constants (black through white) and the code-to-channel expansion function.
REQ-021 Per-frame state (pending/active mode, offset, phase, cyc, frame counter) SHALL live in one sub-module, pattern_frame_ctrl; the pixel pipeline stays in pattern_gen.

Verification
REQ-022 Bench SHALL cover these directed scenarios:
- Mode 0, x = 0, 79, 80, 639, pix_valid = 1 -> 2 cycles later codes 0, 0, 1 (r = 0x3FF, g = b = 0), 7; out_valid = 1.
- Mode 1, 160 frame_starts -> offset 0 (wrap); after 1 frame, x = 636 -> xe = 0 -> black.
- mode_load with mode_sel = 2 mid-frame -> output stays bars until frame_start, then x = 32, y = 0 -> white.
- Mode 3, HOLD_FRAMES = 2, 16 frame_starts -> cyc 0 (wrapped).
- pix_valid = 0 -> r/g/b = 0 and out_valid = 0 after 2 cycles; x = 700 with pix_valid = 1 -> black, out_valid = 1.
- resetn pulsed low mid-frame in mode 1 with offset = 40 -> outputs 0 at once; after release, mode 0 and offset 0.
